elevator_sched: RTL and testbench

ELEVATOR_SCHED -- requirements
Module: elevator_sched

---
 rtl/elevator_sched.sv | 174 +++++++++++++++++
 tb/tb_elevator_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/elevator_sched.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_sched
//  Brief    : Single-car, four-floor elevator scheduler with SCAN ordering.
//             Latches call buttons into a pending mask, moves one floor per
//             MOVE_CYCLES clocks, and holds the door for DOOR_CYCLES clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_sched #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [1:0] floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [3:0] pending,
    output logic       busy
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_MOVE_UP   = 2'd1;
    localparam logic [1:0] c_MOVE_DOWN = 2'd2;
    localparam logic [1:0] c_DOOR      = 2'd3;

    // One counter serves both travel and door timing; it only ever counts
    // up to the larger of the two periods minus one.
    localparam int c_CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_MOVE_LAST = c_CNT_W'(MOVE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DOOR_LAST = c_CNT_W'(DOOR_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         r_floor;
    logic               r_dir;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_pending;

    logic [1:0]         w_up_floor;
    logic [1:0]         w_dn_floor;
    logic               w_here;
    logic               w_above;
    logic               w_below;
    logic               w_move_done;
    logic               w_door_done;
    logic               w_req_here;
    logic [3:0]         w_clr;
    logic [3:0]         w_set;
    logic [3:0]         w_pend_next;

    function automatic logic [3:0] f_onehot(input logic [1:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (2'(i) == f);
        return m;
    endfunction

    function automatic logic [3:0] f_above(input logic [1:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (2'(i) > f);
        return m;
    endfunction

    function automatic logic [3:0] f_below(input logic [1:0] f);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (2'(i) < f);
        return m;
    endfunction

    assign w_up_floor  = r_floor + 2'd1;
    assign w_dn_floor  = r_floor - 2'd1;
    assign w_here      = r_pending[r_floor];
    assign w_above     = |(r_pending & f_above(r_floor));
    assign w_below     = |(r_pending & f_below(r_floor));
    assign w_move_done = (r_cnt == c_MOVE_LAST);
    assign w_door_done = (r_cnt == c_DOOR_LAST);
    assign w_req_here  = req[r_floor];

    // Next pending mask: new calls latch, the floor whose door opens on this
    // edge is cleared (clear beats a simultaneous set), and a call for the
    // floor whose door is already open is absorbed rather than latched.
    always_comb begin
        w_clr = 4'b0000;
        w_set = req;
        case (r_state)
            c_IDLE: begin
                if (w_here) w_clr = f_onehot(r_floor);
            end
            c_MOVE_UP: begin
                if (w_move_done && r_pending[w_up_floor]) w_clr = f_onehot(w_up_floor);
            end
            c_MOVE_DOWN: begin
                if (w_move_done && r_pending[w_dn_floor]) w_clr = f_onehot(w_dn_floor);
            end
            default: begin
                w_set = req & ~f_onehot(r_floor);
            end
        endcase
        w_pend_next = (r_pending | w_set) & ~w_clr;
    end

    // Scheduler state machine: all decisions look at the registered pending
    // mask, so a button press influences motion one cycle after it latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_floor   <= 2'd0;
            r_dir     <= 1'b1;
            r_cnt     <= '0;
            r_pending <= 4'b0000;
        end else begin
            r_pending <= w_pend_next;
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (w_here) begin
                        r_state <= c_DOOR;
                    end else if (w_above && (r_dir || !w_below)) begin
                        r_state <= c_MOVE_UP;
                        r_dir   <= 1'b1;
                    end else if (w_below) begin
                        r_state <= c_MOVE_DOWN;
                        r_dir   <= 1'b0;
                    end
                end
                c_MOVE_UP: begin
                    if (w_move_done) begin
                        r_floor <= w_up_floor;
                        r_cnt   <= '0;
                        if (r_pending[w_up_floor])
                            r_state <= c_DOOR;
                        else if (!(|(r_pending & f_above(w_up_floor))))
                            r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_MOVE_DOWN: begin
                    if (w_move_done) begin
                        r_floor <= w_dn_floor;
                        r_cnt   <= '0;
                        if (r_pending[w_dn_floor])
                            r_state <= c_DOOR;
                        else if (!(|(r_pending & f_below(w_dn_floor))))
                            r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_req_here) begin
                        r_cnt <= '0;
                    end else if (w_door_done) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign floor      = r_floor;
    assign pending    = r_pending;
    assign motor_up   = (r_state == c_MOVE_UP);
    assign motor_down = (r_state == c_MOVE_DOWN);
    assign door_open  = (r_state == c_DOOR);
    assign busy       = (r_state != c_IDLE) || (|r_pending);

endmodule
`default_nettype wire

// File: tb/tb_elevator_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevator_sched
//  Brief    : Directed, self-checking bench for elevator_sched with
//             MOVE_CYCLES=4 and DOOR_CYCLES=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [3:0] pending;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rs;
        logic [3:0] rq;
        logic [1:0] ef;
        logic       emu;
        logic       emd;
        logic       edr;
        logic [3:0] ep;
        logic       eb;
        string      nm;
    } vec_t;

    vec_t vecs[$];

    elevator_sched #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .floor      (floor),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Drive inputs on the falling edge, let one rising edge pass, then
    // compare every output against the expected post-edge values.
    task automatic cyc(input logic rs, input logic [3:0] rq, input logic [1:0] ef,
                       input logic emu, input logic emd, input logic edr,
                       input logic [3:0] ep, input logic eb, input string nm);
        logic [9:0] act;
        logic [9:0] want;
        @(negedge clk);
        reset = rs;
        req   = rq;
        @(posedge clk);
        #1;
        act  = {floor, motor_up, motor_down, door_open, pending, busy};
        want = {ef, emu, emd, edr, ep, eb};
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got floor=%0d up=%b dn=%b door=%b pend=%b busy=%b, want floor=%0d up=%b dn=%b door=%b pend=%b busy=%b",
                     nm, floor, motor_up, motor_down, door_open, pending, busy,
                     ef, emu, emd, edr, ep, eb);
        end
    endtask

    function automatic vec_t mk(input logic rs, input logic [3:0] rq, input logic [1:0] ef,
                                input logic emu, input logic emd, input logic edr,
                                input logic [3:0] ep, input logic eb, input string nm);
        vec_t v;
        v.rs = rs; v.rq = rq; v.ef = ef; v.emu = emu; v.emd = emd;
        v.edr = edr; v.ep = ep; v.eb = eb; v.nm = nm;
        return v;
    endfunction

    initial begin
        // Reset, idle, single-floor door cycle, and clear-beats-set at door entry.
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "reset0"));
        vecs.push_back(mk(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, "reset_overrides_req"));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "idle_after_reset"));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 1, "req0_latch"));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, "door0_entry"));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, "door0_c2"));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, "door0_c3"));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "door0_idle"));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 1, "clrwin_latch"));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 1, 4'b0000, 1, "clrwin_entry"));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, "clrwin_c2"));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, "clrwin_c3"));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "clrwin_idle"));

        foreach (vecs[i])
            cyc(vecs[i].rs, vecs[i].rq, vecs[i].ef, vecs[i].emu, vecs[i].emd,
                vecs[i].edr, vecs[i].ep, vecs[i].eb, vecs[i].nm);

        // Full climb 0 -> 3 on a single call.
        cyc(0, 4'b1000, 0, 0, 0, 0, 4'b1000, 1, "climb_latch");
        for (int k = 0; k < 12; k++)
            cyc(0, 4'b0000, 2'(k / 4), 1, 0, 0, 4'b1000, 1, "climb_move");
        for (int k = 0; k < 3; k++)
            cyc(0, 4'b0000, 3, 0, 0, 1, 4'b0000, 1, "climb_door3");
        cyc(0, 4'b0000, 3, 0, 0, 0, 4'b0000, 0, "climb_idle");

        // Reset from floor 3 returns the car to floor 0.
        cyc(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "reset_f3_a");
        cyc(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "reset_f3_b");

        // SCAN ordering: 3 pending, 2 added in transit, 0 added at floor 1.
        cyc(0, 4'b1000, 0, 0, 0, 0, 4'b1000, 1, "scan_latch");
        cyc(0, 4'b0000, 0, 1, 0, 0, 4'b1000, 1, "scan_go_up");
        cyc(0, 4'b0100, 0, 1, 0, 0, 4'b1100, 1, "scan_add2");
        cyc(0, 4'b0000, 0, 1, 0, 0, 4'b1100, 1, "scan_mv");
        cyc(0, 4'b0000, 0, 1, 0, 0, 4'b1100, 1, "scan_mv");
        cyc(0, 4'b0000, 1, 1, 0, 0, 4'b1100, 1, "scan_pass1");
        cyc(0, 4'b0001, 1, 1, 0, 0, 4'b1101, 1, "scan_add0");
        cyc(0, 4'b0000, 1, 1, 0, 0, 4'b1101, 1, "scan_mv");
        cyc(0, 4'b0000, 1, 1, 0, 0, 4'b1101, 1, "scan_mv");
        for (int k = 0; k < 3; k++)
            cyc(0, 4'b0000, 2, 0, 0, 1, 4'b1001, 1, "scan_door2");
        cyc(0, 4'b0000, 2, 0, 0, 0, 4'b1001, 1, "scan_idle2");
        for (int k = 0; k < 4; k++)
            cyc(0, 4'b0000, 2, 1, 0, 0, 4'b1001, 1, "scan_up_to3");
        for (int k = 0; k < 3; k++)
            cyc(0, 4'b0000, 3, 0, 0, 1, 4'b0001, 1, "scan_door3");
        cyc(0, 4'b0000, 3, 0, 0, 0, 4'b0001, 1, "scan_idle3");
        for (int k = 0; k < 12; k++)
            cyc(0, 4'b0000, 2'(3 - k / 4), 0, 1, 0, 4'b0001, 1, "scan_down");
        for (int k = 0; k < 3; k++)
            cyc(0, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, "scan_door0");
        cyc(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "scan_idle0");

        // Door hold: call for the open floor keeps the door open, never latches.
        cyc(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 1, "hold_latch");
        for (int k = 0; k < 4; k++)
            cyc(0, 4'b0000, 0, 1, 0, 0, 4'b0010, 1, "hold_up");
        cyc(0, 4'b0000, 1, 0, 0, 1, 4'b0000, 1, "hold_door_entry");
        for (int k = 0; k < 5; k++)
            cyc(0, 4'b0010, 1, 0, 0, 1, 4'b0000, 1, "hold_req_held");
        cyc(0, 4'b0000, 1, 0, 0, 1, 4'b0000, 1, "hold_after1");
        cyc(0, 4'b0000, 1, 0, 0, 1, 4'b0000, 1, "hold_after2");
        cyc(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, "hold_closed");

        // At floor 1 heading up with calls both above and below: up wins.
        cyc(0, 4'b1001, 1, 0, 0, 0, 4'b1001, 1, "prio_latch");
        cyc(0, 4'b0000, 1, 1, 0, 0, 4'b1001, 1, "prio_up_first");

        // Reset two cycles into a climb from floor 0 abandons the step.
        cyc(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "midreset_prep");
        cyc(0, 4'b1000, 0, 0, 0, 0, 4'b1000, 1, "midreset_latch");
        cyc(0, 4'b0000, 0, 1, 0, 0, 4'b1000, 1, "midreset_up1");
        cyc(0, 4'b0000, 0, 1, 0, 0, 4'b1000, 1, "midreset_up2");
        cyc(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "midreset_hit");
        for (int k = 0; k < 6; k++)
            cyc(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, "midreset_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
